// File: rtl/calc_display_scan_if.sv
// Bundle between the calculator core's digit stream and the display driver.
// Core side: status / data / pos are presented every cycle, there is no
// valid/ready pair. status == 01 (busy) qualifies data/pos as a digit write,
// the 01 -> 10 (ready) transition marks the end of a frame, 00 reports an
// error and 11 is reserved and carries no meaning. The display side
// (an/seg/dp) plus the frame_valid/err flags are driven back by the scanner.
interface calc_display_scan_if;
    logic [1:0] status;
    logic [3:0] data;
    logic [3:0] pos;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_valid;
    logic       err;

    // The core (or a bench standing in for it) drives the digit stream.
    modport master (
        output status, data, pos,
        input  an, seg, dp, frame_valid, err
    );

    // The display scanner consumes the stream and drives the display.
    modport slave (
        input  status, data, pos,
        output an, seg, dp, frame_valid, err
    );
endinterface

// File: rtl/calc_display_scan.sv
// Calculator display scanner.
// Captures the core's BCD digit stream into a shadow buffer, commits a full
// frame into the display buffer on the busy -> ready edge, and time-multiplexes
// the display buffer onto an 8-digit common-anode seven-segment display.
// A core error status latches a sticky "Err" screen until reset.
// Optional build macro CALC_DISPLAY_LZB_EN enables leading-zero blanking of
// the committed frame (digit 0 is never blanked; the error screen is unaffected).
module calc_display_scan #(
    parameter int SCAN_DIV = 100000, // clock cycles per digit slot, >= 2
    parameter int NUM_DIG  = 8       // fixed at 8
) (
    input  logic                 clock,
    input  logic                 reset,
    calc_display_scan_if.slave   bus
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] ST_ERR   = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Fixed "Err" pattern right-aligned on digits 2..0.
    function automatic logic [6:0] err_glyph(input logic [2:0] idx);
        logic [6:0] s;
        case (idx)
            3'd2:       s = SEG_E;
            3'd1, 3'd0: s = SEG_R;
            default:    s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [NUM_DIG-1:0][3:0] shadow;
    logic [NUM_DIG-1:0][3:0] disp;
    logic [PW-1:0]           prescaler;
    logic [2:0]              scan_idx;
    logic [1:0]              status_q;
    logic                    err_q;
    logic                    frame_valid_q;
    logic [7:0]              an_q;
    logic [6:0]              seg_q;

    logic                    capture_en;
    logic                    commit_en;
    logic                    scan_wrap;
    logic [NUM_DIG-1:0]      lz_blank;
    logic [7:0]              an_next;
    logic [6:0]              seg_next;

    // Capture needs busy status, commit needs the busy->ready edge; both are
    // frozen once the sticky error is set. pos >= 8 is ignored outright.
    always_comb begin
        capture_en = !err_q && (bus.status == ST_BUSY) && !bus.pos[3];
        commit_en  = !err_q && (status_q == ST_BUSY) && (bus.status == ST_READY);
        scan_wrap  = (prescaler == PW'(SCAN_DIV - 1));
    end

    // Shadow buffer: one digit per busy cycle, addressed by pos.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (capture_en) begin
            shadow[bus.pos[2:0]] <= bus.data;
        end
    end

    // Display buffer: whole frame copied from the shadow on commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            disp          <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= commit_en;
            if (commit_en) begin
                disp <= shadow;
            end
        end
    end

    // Previous-cycle status for edge detection, and the sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status_q <= ST_BUSY;
            err_q    <= 1'b0;
        end else begin
            status_q <= bus.status;
            if (bus.status == ST_ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    // Slot timer: prescaler wraps every SCAN_DIV cycles and advances the slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            scan_idx  <= 3'd0;
        end else if (scan_wrap) begin
            prescaler <= '0;
            scan_idx  <= scan_idx + 3'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

`ifdef CALC_DISPLAY_LZB_EN
    // A digit is blank while it and every digit above it are zero; digit 0
    // always shows so that a zero value displays a single '0'.
    always_comb begin
        logic seen_nz;
        lz_blank = '0;
        seen_nz  = 1'b0;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            if (disp[k] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lz_blank[k] = !seen_nz;
        end
    end
`else
    // Without blanking every digit is decoded, leading zeros included.
    always_comb begin
        lz_blank = '0;
    end
`endif

    // Pattern for the slot currently selected by scan_idx.
    always_comb begin
        an_next  = ~(NUM_DIG'(1) << scan_idx);
        seg_next = SEG_BLANK;
        if (err_q) begin
            seg_next = err_glyph(scan_idx);
        end else if (lz_blank[scan_idx]) begin
            seg_next = SEG_BLANK;
        end else begin
            seg_next = seg_decode(disp[scan_idx]);
        end
    end

    // Registered display drive, one clock behind scan_idx.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_q  <= 8'hFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_next;
            seg_q <= seg_next;
        end
    end

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.dp          = 1'b1;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_calc_display_scan.sv
// Bench for calc_display_scan with SCAN_DIV = 4. A behavioural model of the
// frame buffers, error flag and slot timing predicts every output each cycle;
// directed sequences pin the model with literal segment values.
// Honours CALC_DISPLAY_LZB_EN for the expected blanking.
module tb_calc_display_scan;
    localparam int SCAN_DIV = 4;

`ifdef CALC_DISPLAY_LZB_EN
    localparam logic [6:0] LEAD0 = 7'h7F;
`else
    localparam logic [6:0] LEAD0 = 7'h40;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    calc_display_scan_if bus ();

    calc_display_scan #(.SCAN_DIV(SCAN_DIV), .NUM_DIG(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_bad  = 0;
    int fv_cnt = 0;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    int         m_shadow [8];
    int         m_disp   [8];
    bit         m_err;
    logic [1:0] m_stq;
    int         m_edges;

    // What a digit slot must show given the current committed frame.
    function automatic logic [6:0] model_seg(input int slot);
        int msd;
        if (m_err) begin
            if (slot == 2) return 7'h06;
            if (slot < 2)  return 7'h2F;
            return 7'h7F;
        end
        msd = 0;
        for (int k = 0; k < 8; k++) if (m_disp[k] != 0) msd = k;
`ifdef CALC_DISPLAY_LZB_EN
        if (slot > msd) return 7'h7F;
`endif
        return seg_tab[m_disp[slot]];
    endfunction

    // Step the model on each edge, then compare all outputs just after it.
    always @(posedge clock) begin
        logic [7:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fv;
        int         slot;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = 0;
                m_disp[i]   = 0;
            end
            m_err   = 1'b0;
            m_stq   = 2'b01;
            m_edges = 0;
            exp_an  = 8'hFF;
            exp_seg = 7'h7F;
            exp_fv  = 1'b0;
        end else begin
            slot    = (m_edges / SCAN_DIV) % 8;
            exp_an  = ~(8'h01 << slot);
            exp_seg = model_seg(slot);
            exp_fv  = !m_err && (m_stq == 2'b01) && (bus.status == 2'b10);
            if (exp_fv) for (int i = 0; i < 8; i++) m_disp[i] = m_shadow[i];
            if (!m_err && bus.status == 2'b01 && bus.pos < 8)
                m_shadow[bus.pos] = int'(bus.data);
            if (bus.status == 2'b00) m_err = 1'b1;
            m_stq = bus.status;
            m_edges++;
        end
        #1;
        check("an",  bus.an,  exp_an);
        check("seg", bus.seg, exp_seg);
        check("frame_valid", bus.frame_valid, exp_fv);
        check("err", bus.err, m_err);
        check("dp",  bus.dp,  1'b1);
        if (bus.frame_valid === 1'b1) fv_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] st, input logic [3:0] d, input logic [3:0] p);
        bus.status = st;
        bus.data   = d;
        bus.pos    = p;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b01, 4'd0, 4'd8);
    endtask

    task automatic commit();
        drive(2'b10, 4'd0, 4'd8);
        drive(2'b01, 4'd0, 4'd8);
    endtask

    // Wait (bounded) for a given digit enable and check the pattern shown there.
    task automatic check_slot(input logic [7:0] want_an, input logic [6:0] want_seg,
                              input string name);
        bit found = 1'b0;
        for (int i = 0; i < 8 * SCAN_DIV + 4; i++) begin
            @(negedge clock);
            if (bus.an === want_an) begin
                found = 1'b1;
                break;
            end
        end
        check({name, "_reached"}, found, 1'b1);
        if (found) check(name, bus.seg, want_seg);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] frame_vals [8] = '{4'd5, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    int fv0;
    int r;

    initial begin
        bus.status = 2'b01;
        bus.data   = 4'd0;
        bus.pos    = 4'd8;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_an",  bus.an,  8'hFF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_err", bus.err, 1'b0);
        check("rst_fv",  bus.frame_valid, 1'b0);

        // Idle scan over an all-zero frame.
        idle(40);
        check_slot(8'hFE, 7'h40, "idle_d0");
        check_slot(8'hFD, LEAD0, "idle_d1");

        // Full frame 5,2,0.. then commit.
        for (int i = 0; i < 8; i++) drive(2'b01, frame_vals[i], 4'(i));
        fv0 = fv_cnt;
        commit();
        idle(2);
        check("frame_fv_count", fv_cnt - fv0, 1);
        check_slot(8'hFE, 7'h12, "frame_d0");
        check_slot(8'hFD, 7'h24, "frame_d1");
        check_slot(8'hFB, LEAD0, "frame_d2");
        check_slot(8'h7F, LEAD0, "frame_d7");

        // Partial update held in the shadow until the next ready edge.
        drive(2'b01, 4'd9, 4'd0);
        idle(20);
        check_slot(8'hFE, 7'h12, "partial_hold_d0");
        fv0 = fv_cnt;
        drive(2'b10, 4'd0, 4'd8);
        drive(2'b10, 4'd0, 4'd8);
        idle(2);
        check("partial_fv_count", fv_cnt - fv0, 1);
        check_slot(8'hFE, 7'h10, "partial_d0");

        // Out-of-range position and non-BCD data.
        drive(2'b01, 4'd7, 4'd9);
        drive(2'b01, 4'd12, 4'd3);
        commit();
        check_slot(8'hF7, 7'h7F, "nonbcd_d3");
        check_slot(8'hFD, 7'h24, "pos9_ignored_d1");

        // Randomised traffic without errors.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            drive((r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        idle(4);

        // Error screen, sticky and blocking commits.
        drive(2'b00, 4'd3, 4'd0);
        idle(3);
        check("err_set", bus.err, 1'b1);
        check_slot(8'hFB, 7'h06, "err_d2");
        check_slot(8'hFD, 7'h2F, "err_d1");
        check_slot(8'hFE, 7'h2F, "err_d0");
        check_slot(8'hEF, 7'h7F, "err_d4");
        fv0 = fv_cnt;
        drive(2'b01, 4'd1, 4'd0);
        commit();
        idle(2);
        check("err_no_commit", fv_cnt - fv0, 0);
        check("err_sticky", bus.err, 1'b1);

        // Asynchronous reset mid-scan while in error.
        idle(5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_an",  bus.an,  8'hFF);
        check("async_rst_seg", bus.seg, 7'h7F);
        check("async_rst_err", bus.err, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("restart_an", bus.an, 8'hFE);
        check_slot(8'hFE, 7'h40, "post_rst_d0");
        check_slot(8'hFD, LEAD0, "post_rst_d1");

        // Second random run, occasionally including an error cycle late on.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            drive((r < 65) ? 2'b01 : (r < 90) ? 2'b10 : (r < 99) ? 2'b11 : 2'b00,
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
